lsu_sequencer: RTL and testbench



---
 rtl/lsu_sequencer_if.sv | 49 ++++
 rtl/lsu_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_lsu_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_sequencer_if.sv
// lsu_sequencer_if.sv
// Request/response and data-bus signals of the load/store sequencer.
// master: requesting core, slave: sequencer, mem_slave: data-bus target.
interface lsu_sequencer_if;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned STRB_W        = DATA_W / 8;
    localparam int unsigned LOAD_OP_WIDTH = 3;

    // Core-side request
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [ADDR_W-1:0]        req_addr;
    logic [LOAD_OP_WIDTH-1:0] req_load_op;
    logic [1:0]               req_store_size;
    logic [DATA_W-1:0]        req_wdata;

    // Core-side response
    logic                     resp_valid;
    logic [DATA_W-1:0]        resp_rdata;
    logic                     resp_misaligned;
    logic                     resp_buserr;

    // Data bus
    logic                     mem_valid;
    logic                     mem_ready;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [STRB_W-1:0]        mem_wstrb;
    logic [DATA_W-1:0]        mem_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_load_op, req_store_size, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_buserr
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_load_op, req_store_size, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_buserr,
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport mem_slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu_sequencer.sv
// lsu_sequencer.sv
// Multicycle load/store sequencer: one access at a time, word-aligned bus
// cycle with byte strobes and replicated store data, bus timeout, and an
// aligned/sign-extended load result returned as a one-cycle response.
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned accesses
// with no bus cycle; without it misaligned accesses are issued as-is.
// Load-op encoding (RISC-V funct3): LB=000 LH=001 LW=010 LBU=100 LHU=101.

module load_alignment #(
    parameter int unsigned LOAD_OP_WIDTH = 3
) (
    input  logic [1:0]               i_addr_lo,
    input  logic [LOAD_OP_WIDTH-1:0] i_load_op,
    input  logic [31:0]              i_data,
    output logic [31:0]              o_data
);
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LB  = LOAD_OP_WIDTH'(0);
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LH  = LOAD_OP_WIDTH'(1);
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LW  = LOAD_OP_WIDTH'(2);
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LBU = LOAD_OP_WIDTH'(4);
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LHU = LOAD_OP_WIDTH'(5);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte and half lane select from the low address bits
    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0: w_byte = i_data[7:0];
            2'd1: w_byte = i_data[15:8];
            2'd2: w_byte = i_data[23:16];
            2'd3: w_byte = i_data[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_addr_lo[1] ? i_data[31:16] : i_data[15:0];
    end

    // Sign or zero extension by load op
    always_comb begin
        o_data = 32'h0;
        case (i_load_op)
            LOAD_OP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            LOAD_OP_LBU: o_data = {24'h0, w_byte};
            LOAD_OP_LH:  o_data = {{16{w_half[15]}}, w_half};
            LOAD_OP_LHU: o_data = {16'h0, w_half};
            LOAD_OP_LW:  o_data = i_data;
            default:     o_data = 32'h0;
        endcase
    end
endmodule

module lsu_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic           clk,
    input  logic           resetn,
    lsu_sequencer_if.slave bus
);
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned STRB_W        = DATA_W / 8;
    localparam int unsigned LOAD_OP_WIDTH = 3;
    localparam int unsigned TMO_W         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TMO_EN        = (TIMEOUT_CYCLES != 0);

    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LH  = LOAD_OP_WIDTH'(1);
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LW  = LOAD_OP_WIDTH'(2);
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LHU = LOAD_OP_WIDTH'(5);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    // Registered outputs
    logic                     r_req_ready;
    logic                     r_mem_valid;
    logic                     r_resp_valid;
    logic [DATA_W-1:0]        r_resp_rdata;
    logic                     r_resp_misaligned;
    logic                     r_resp_buserr;
    logic [ADDR_W-1:0]        r_mem_addr;
    logic [DATA_W-1:0]        r_mem_wdata;
    logic [STRB_W-1:0]        r_mem_wstrb;

    // Captured request context
    logic [1:0]               r_addr_lo;
    logic [LOAD_OP_WIDTH-1:0] r_load_op;
    logic                     r_we;
    logic [TMO_W-1:0]         r_tmo_cnt;

    logic                     w_accept;
    logic                     w_is_word;
    logic                     w_is_half;
    logic                     w_misaligned;
    logic [DATA_W-1:0]        w_wdata;
    logic [STRB_W-1:0]        w_wstrb;
    logic                     w_timeout;
    logic [DATA_W-1:0]        w_load_data;
    logic [TMO_W-1:0]         w_tmo_cnt_nxt;
    logic [DATA_W-1:0]        w_resp_rdata_nxt;
    logic                     w_resp_misaligned_nxt;
    logic                     w_resp_buserr_nxt;

    assign w_accept  = (r_state == ST_IDLE) && bus.req_valid;
    assign w_timeout = TMO_EN && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // Access size of the incoming request (store size 11 behaves as word)
    always_comb begin
        w_is_word = 1'b0;
        w_is_half = 1'b0;
        if (bus.req_we) begin
            w_is_word = bus.req_store_size[1];
            w_is_half = (bus.req_store_size == 2'b01);
        end else begin
            w_is_word = (bus.req_load_op == LOAD_OP_LW);
            w_is_half = (bus.req_load_op == LOAD_OP_LH) || (bus.req_load_op == LOAD_OP_LHU);
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Halves need addr[0]=0, words need addr[1:0]=00; bytes always fit
    assign w_misaligned = (w_is_half && bus.req_addr[0])
                       || (w_is_word && (bus.req_addr[1:0] != 2'b00));
`else
    // No alignment check: misaligned accesses go out on the low address bits
    assign w_misaligned = 1'b0;
`endif

    // Store lane replication and byte strobes; loads drive zero
    always_comb begin
        w_wdata = '0;
        w_wstrb = '0;
        if (bus.req_we) begin
            if (w_is_word) begin
                w_wdata = bus.req_wdata;
                w_wstrb = 4'b1111;
            end else if (w_is_half) begin
                w_wdata = {2{bus.req_wdata[15:0]}};
                w_wstrb = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            end else begin
                w_wdata = {4{bus.req_wdata[7:0]}};
                w_wstrb = 4'b0001 << bus.req_addr[1:0];
            end
        end
    end

    // Bus read data is aligned as it is captured into the response register
    load_alignment #(
        .LOAD_OP_WIDTH (LOAD_OP_WIDTH)
    ) u_load_align (
        .i_addr_lo (r_addr_lo),
        .i_load_op (r_load_op),
        .i_data    (bus.mem_rdata),
        .o_data    (w_load_data)
    );

    // Next state, timeout counter and response payload
    always_comb begin
        w_state_nxt           = r_state;
        w_tmo_cnt_nxt         = r_tmo_cnt;
        w_resp_rdata_nxt      = '0;
        w_resp_misaligned_nxt = 1'b0;
        w_resp_buserr_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_misaligned) begin
                        w_state_nxt           = ST_RESP;
                        w_resp_misaligned_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = ST_ACCESS;
                        w_tmo_cnt_nxt = '0;
                    end
                end
            end
            ST_ACCESS: begin
                // Ready on the terminal-count cycle still completes normally
                if (bus.mem_ready) begin
                    w_state_nxt      = ST_RESP;
                    w_resp_rdata_nxt = r_we ? '0 : w_load_data;
                end else if (w_timeout) begin
                    w_state_nxt       = ST_RESP;
                    w_resp_buserr_nxt = 1'b1;
                end else if (TMO_EN) begin
                    w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register with control and response outputs registered from next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state           <= ST_IDLE;
            r_req_ready       <= 1'b1;
            r_mem_valid       <= 1'b0;
            r_resp_valid      <= 1'b0;
            r_resp_rdata      <= '0;
            r_resp_misaligned <= 1'b0;
            r_resp_buserr     <= 1'b0;
            r_tmo_cnt         <= '0;
        end else begin
            r_state           <= w_state_nxt;
            r_req_ready       <= (w_state_nxt == ST_IDLE);
            r_mem_valid       <= (w_state_nxt == ST_ACCESS);
            r_resp_valid      <= (w_state_nxt == ST_RESP);
            r_resp_rdata      <= w_resp_rdata_nxt;
            r_resp_misaligned <= w_resp_misaligned_nxt;
            r_resp_buserr     <= w_resp_buserr_nxt;
            r_tmo_cnt         <= w_tmo_cnt_nxt;
        end
    end

    // Request capture: bus address/lanes held stable for the whole bus cycle
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_addr_lo   <= '0;
            r_load_op   <= '0;
            r_we        <= 1'b0;
        end else if (w_accept) begin
            r_mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            r_mem_wdata <= w_wdata;
            r_mem_wstrb <= w_wstrb;
            r_addr_lo   <= bus.req_addr[1:0];
            r_load_op   <= bus.req_load_op;
            r_we        <= bus.req_we;
        end
    end

    assign bus.req_ready       = r_req_ready;
    assign bus.resp_valid      = r_resp_valid;
    assign bus.resp_rdata      = r_resp_rdata;
    assign bus.resp_misaligned = r_resp_misaligned;
    assign bus.resp_buserr     = r_resp_buserr;
    assign bus.mem_valid       = r_mem_valid;
    assign bus.mem_addr        = r_mem_addr;
    assign bus.mem_wdata       = r_mem_wdata;
    assign bus.mem_wstrb       = r_mem_wstrb;
endmodule

// File: tb/tb_lsu_sequencer.sv
// tb_lsu_sequencer.sv
// Scenario tasks drive the sequencer; expected responses go into a queue
// that a response monitor pops whenever resp_valid is seen.
module tb_lsu_sequencer;
    localparam int unsigned TMO = 8;
    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        berr;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   resp_cyc[$];

    lsu_sequencer_if u_bus ();

    lsu_sequencer #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (u_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Response monitor: pop and compare every completion
    always @(negedge clk) begin
        exp_t e;
        if (resetn && u_bus.resp_valid) begin
            resp_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding (rdata=%h)", u_bus.resp_rdata);
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (u_bus.resp_rdata !== e.rdata) begin
                    n_errors++;
                    $display("FAIL resp_rdata: got %h want %h", u_bus.resp_rdata, e.rdata);
                end
                n_checks++;
                if (u_bus.resp_misaligned !== e.mis) begin
                    n_errors++;
                    $display("FAIL resp_misaligned: got %b want %b", u_bus.resp_misaligned, e.mis);
                end
                n_checks++;
                if (u_bus.resp_buserr !== e.berr) begin
                    n_errors++;
                    $display("FAIL resp_buserr: got %b want %b", u_bus.resp_buserr, e.berr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Issue one request at the current negedge (sequencer idle) and act as the bus.
    // Returns the first bus beat, number of mem_valid cycles and accept-to-response latency.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [2:0] op,
                              input logic [1:0] size, input logic [31:0] wdata,
                              input logic [31:0] bus_rdata, input int waits,
                              output logic [31:0] o_addr, output logic [3:0] o_strb,
                              output logic [31:0] o_wdata, output int vc, output int lat);
        bit done = 1'b0;
        o_addr  = 'x;
        o_strb  = 'x;
        o_wdata = 'x;
        u_bus.req_valid      = 1'b1;
        u_bus.req_we         = we;
        u_bus.req_addr       = addr;
        u_bus.req_load_op    = op;
        u_bus.req_store_size = size;
        u_bus.req_wdata      = wdata;
        @(negedge clk);
        u_bus.req_valid      = 1'b0;
        u_bus.req_we         = 1'($urandom);
        u_bus.req_addr       = $urandom;
        u_bus.req_load_op    = 3'($urandom);
        u_bus.req_store_size = 2'($urandom);
        u_bus.req_wdata      = $urandom;
        vc  = 0;
        lat = 1;
        for (int i = 0; i < 64 && !done; i++) begin
            if (u_bus.resp_valid) begin
                done = 1'b1;
            end else begin
                if (u_bus.mem_valid) begin
                    if (vc == 0) begin
                        o_addr  = u_bus.mem_addr;
                        o_strb  = u_bus.mem_wstrb;
                        o_wdata = u_bus.mem_wdata;
                    end
                    vc++;
                    u_bus.mem_ready = (vc > waits);
                    u_bus.mem_rdata = (vc > waits) ? bus_rdata : $urandom;
                end else begin
                    u_bus.mem_ready = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
        end
        u_bus.mem_ready = 1'b0;
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL access_wait: no response within 64 cycles for addr %h", addr);
        end
        @(negedge clk);
    endtask

    task automatic test_reset(input string tag);
        resetn               = 1'b0;
        u_bus.req_valid      = 1'b0;
        u_bus.req_we         = 1'b0;
        u_bus.req_addr       = '0;
        u_bus.req_load_op    = '0;
        u_bus.req_store_size = '0;
        u_bus.req_wdata      = '0;
        u_bus.mem_ready      = 1'b0;
        u_bus.mem_rdata      = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({u_bus.resp_valid, u_bus.mem_valid} !== 2'b00) begin
            n_errors++;
            $display("FAIL %s_in_reset: resp_valid,mem_valid got %b want 00", tag, {u_bus.resp_valid, u_bus.mem_valid});
        end
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({u_bus.req_ready, u_bus.resp_valid, u_bus.resp_misaligned, u_bus.resp_buserr, u_bus.mem_valid} !== 5'b10000) begin
            n_errors++;
            $display("FAIL %s_ctrl: ready,rvalid,mis,berr,mvalid got %b want 10000", tag,
                     {u_bus.req_ready, u_bus.resp_valid, u_bus.resp_misaligned, u_bus.resp_buserr, u_bus.mem_valid});
        end
        n_checks++;
        if (u_bus.resp_rdata !== 32'h0) begin
            n_errors++;
            $display("FAIL %s_rdata: got %h want 0", tag, u_bus.resp_rdata);
        end
        n_checks++;
        if ({u_bus.mem_addr, u_bus.mem_wdata, u_bus.mem_wstrb} !== 68'h0) begin
            n_errors++;
            $display("FAIL %s_bus: addr %h wdata %h wstrb %b want all 0", tag, u_bus.mem_addr, u_bus.mem_wdata, u_bus.mem_wstrb);
        end
    endtask

    task automatic test_load();
        logic [31:0] a, w;
        logic [3:0]  s;
        int          vc, lat;
        logic [31:0] t_addr [5] = '{32'h6000, 32'h6002, 32'h6001, 32'h6004, 32'h6002};
        logic [2:0]  t_op   [5] = '{OP_LH, OP_LHU, OP_LBU, OP_LW, OP_LB};
        logic [31:0] t_bus  [5] = '{32'h1234_8001, 32'h8001_7FFF, 32'h0000_9A00, 32'hA5A5_0F0F, 32'h0055_0000};
        logic [31:0] t_exp  [5] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_009A, 32'hA5A5_0F0F, 32'h0000_0055};
        exp_q.push_back('{32'hFFFF_FF80, 1'b0, 1'b0});
        run_access(1'b0, 32'h1003, OP_LB, 2'b00, 32'h0, 32'h80FF_1234, 2, a, s, w, vc, lat);
        n_checks++;
        if ({a, s, w} !== {32'h1000, 4'b0000, 32'h0}) begin
            n_errors++;
            $display("FAIL lb_bus: addr %h strb %b wdata %h want 00001000 0000 00000000", a, s, w);
        end
        n_checks++;
        if (vc !== 3 || lat !== 4) begin
            n_errors++;
            $display("FAIL lb_timing: valid cycles %0d latency %0d want 3 and 4", vc, lat);
        end
        n_checks++;
        if ({u_bus.req_ready, u_bus.resp_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL lb_after_resp: ready,resp_valid got %b want 10", {u_bus.req_ready, u_bus.resp_valid});
        end
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{t_exp[i], 1'b0, 1'b0});
            run_access(1'b0, t_addr[i], t_op[i], 2'b00, 32'h0, t_bus[i], 0, a, s, w, vc, lat);
            n_checks++;
            if ({a, s} !== {t_addr[i] & 32'hFFFF_FFFC, 4'b0000} || lat !== 2) begin
                n_errors++;
                $display("FAIL load%0d: addr %h strb %b lat %0d want %h 0000 2", i, a, s, lat, t_addr[i] & 32'hFFFF_FFFC);
            end
        end
    endtask

    task automatic test_store();
        logic [31:0] a, w;
        logic [3:0]  s;
        int          vc, lat;
        logic [31:0] t_addr [6] = '{32'h2002, 32'h5001, 32'h5003, 32'h5000, 32'h5004, 32'h5008};
        logic [1:0]  t_size [6] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
        logic [31:0] t_wd   [6] = '{32'hDEAD_BEEF, 32'h0000_00A5, 32'hFFFF_FF3C, 32'h0000_ABCD, 32'hCAFE_F00D, 32'h0123_4567};
        logic [31:0] t_ewd  [6] = '{32'hBEEF_BEEF, 32'hA5A5_A5A5, 32'h3C3C_3C3C, 32'hABCD_ABCD, 32'hCAFE_F00D, 32'h0123_4567};
        logic [3:0]  t_estb [6] = '{4'b1100, 4'b0010, 4'b1000, 4'b0011, 4'b1111, 4'b1111};
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back('{32'h0, 1'b0, 1'b0});
            run_access(1'b1, t_addr[i], OP_LW, t_size[i], t_wd[i], $urandom, 1, a, s, w, vc, lat);
            n_checks++;
            if ({a, s, w} !== {t_addr[i] & 32'hFFFF_FFFC, t_estb[i], t_ewd[i]}) begin
                n_errors++;
                $display("FAIL store%0d: addr %h strb %b wdata %h want %h %b %h", i, a, s, w,
                         t_addr[i] & 32'hFFFF_FFFC, t_estb[i], t_ewd[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] a, w;
        logic [3:0]  s;
        int          vc, lat;
`ifdef LSU_MISALIGN_TRAP_EN
        exp_q.push_back('{32'h0, 1'b1, 1'b0});
        run_access(1'b0, 32'h3001, OP_LW, 2'b00, 32'h0, 32'h1122_3344, 0, a, s, w, vc, lat);
        n_checks++;
        if (vc !== 0 || lat !== 1) begin
            n_errors++;
            $display("FAIL mis_lw: valid cycles %0d latency %0d want 0 and 1", vc, lat);
        end
        exp_q.push_back('{32'h0, 1'b1, 1'b0});
        run_access(1'b1, 32'h2003, OP_LW, 2'b01, 32'h0000_1234, 32'h0, 0, a, s, w, vc, lat);
        n_checks++;
        if (vc !== 0 || lat !== 1) begin
            n_errors++;
            $display("FAIL mis_sh: valid cycles %0d latency %0d want 0 and 1", vc, lat);
        end
`else
        exp_q.push_back('{32'h1122_3344, 1'b0, 1'b0});
        run_access(1'b0, 32'h3001, OP_LW, 2'b00, 32'h0, 32'h1122_3344, 0, a, s, w, vc, lat);
        n_checks++;
        if (a !== 32'h3000 || vc !== 1) begin
            n_errors++;
            $display("FAIL mis_lw: addr %h valid cycles %0d want 00003000 1", a, vc);
        end
        exp_q.push_back('{32'h0, 1'b0, 1'b0});
        run_access(1'b1, 32'h2003, OP_LW, 2'b01, 32'h0000_1234, 32'h0, 0, a, s, w, vc, lat);
        n_checks++;
        if ({a, s, w} !== {32'h2000, 4'b1100, 32'h1234_1234}) begin
            n_errors++;
            $display("FAIL mis_sh: addr %h strb %b wdata %h want 00002000 1100 12341234", a, s, w);
        end
`endif
        exp_q.push_back('{32'h0000_007F, 1'b0, 1'b0});
        run_access(1'b0, 32'h3003, OP_LB, 2'b00, 32'h0, 32'h7F00_0000, 0, a, s, w, vc, lat);
        n_checks++;
        if (a !== 32'h3000 || vc !== 1) begin
            n_errors++;
            $display("FAIL byte_never_mis: addr %h valid cycles %0d want 00003000 1", a, vc);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] a, w;
        logic [3:0]  s;
        int          vc, lat;
        exp_q.push_back('{32'h0, 1'b0, 1'b1});
        run_access(1'b0, 32'h7000, OP_LW, 2'b00, 32'h0, 32'hFFFF_FFFF, 1000, a, s, w, vc, lat);
        n_checks++;
        if (vc !== 8 || lat !== 9) begin
            n_errors++;
            $display("FAIL timeout: valid cycles %0d latency %0d want 8 and 9", vc, lat);
        end
    endtask

    task automatic test_terminal_ready();
        logic [31:0] a, w;
        logic [3:0]  s;
        int          vc, lat;
        exp_q.push_back('{32'h0BAD_F00D, 1'b0, 1'b0});
        run_access(1'b0, 32'h7004, OP_LW, 2'b00, 32'h0, 32'h0BAD_F00D, 7, a, s, w, vc, lat);
        n_checks++;
        if (vc !== 8 || lat !== 9) begin
            n_errors++;
            $display("FAIL terminal_ready: valid cycles %0d latency %0d want 8 and 9", vc, lat);
        end
    endtask

    task automatic test_reset_mid_access();
        u_bus.req_valid   = 1'b1;
        u_bus.req_we      = 1'b0;
        u_bus.req_addr    = 32'h8000;
        u_bus.req_load_op = OP_LW;
        @(negedge clk);
        u_bus.req_valid = 1'b0;
        n_checks++;
        if (u_bus.mem_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_access_setup: mem_valid got %b want 1", u_bus.mem_valid);
        end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({u_bus.mem_valid, u_bus.req_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL async_reset: mem_valid,req_ready got %b want 01", {u_bus.mem_valid, u_bus.req_ready});
        end
        test_reset("mid_access");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, w;
        logic [3:0]  s;
        int          vc, lat;
        resp_cyc.delete();
        exp_q.push_back('{32'h1234_5678, 1'b0, 1'b0});
        run_access(1'b0, 32'h4000, OP_LW, 2'b00, 32'h0, 32'h1234_5678, 0, a, s, w, vc, lat);
        exp_q.push_back('{32'h0, 1'b0, 1'b0});
        run_access(1'b1, 32'h4004, OP_LW, 2'b10, 32'hCAFE_F00D, $urandom, 0, a, s, w, vc, lat);
        n_checks++;
        if ({a, s, w} !== {32'h4004, 4'b1111, 32'hCAFE_F00D}) begin
            n_errors++;
            $display("FAIL b2b_sw: addr %h strb %b wdata %h want 00004004 1111 cafef00d", a, s, w);
        end
        exp_q.push_back('{32'h0F0F_0F0F, 1'b0, 1'b0});
        run_access(1'b0, 32'h4008, OP_LW, 2'b00, 32'h0, 32'h0F0F_0F0F, 0, a, s, w, vc, lat);
        exp_q.push_back('{32'h0, 1'b0, 1'b0});
        run_access(1'b1, 32'h400C, OP_LW, 2'b10, 32'h1357_9BDF, $urandom, 0, a, s, w, vc, lat);
        n_checks++;
        if (resp_cyc.size() !== 4) begin
            n_errors++;
            $display("FAIL b2b_count: responses %0d want 4", resp_cyc.size());
        end
        for (int i = 1; i < resp_cyc.size(); i++) begin
            n_checks++;
            if (resp_cyc[i] - resp_cyc[i-1] !== 3) begin
                n_errors++;
                $display("FAIL b2b_spacing%0d: %0d cycles want 3", i, resp_cyc[i] - resp_cyc[i-1]);
            end
        end
    endtask

    initial begin
        test_reset("power_on");
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_terminal_ready();
        test_reset_mid_access();
        test_back_to_back();
        repeat (2) @(negedge clk);
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL outstanding: %0d expected responses never seen", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
